fusion_retire_split: RTL and testbench

Commit-side counterpart of the issue-stage ADD+LOAD fusion. Accepts committed scoreboard entries one at a time and re-expands each fused entry into two architectural retire events: the absorbed ADD, then the LOAD. It also keeps the architectural instret count correct and reports the byte advance encoded in `is_fusion`. A faulting fused entry is flagged so the frontend can refetch that pair unfused. It sits between the commit stage and the CSR/trace consumers.

---
 rtl/fusion_retire_split_pkg.sv | 61 ++++++
 rtl/fusion_retire_split.sv | 153 +++++++++++++++
 tb/tb_fusion_retire_split.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fusion_retire_split_pkg.sv
// fusion_retire_split_pkg
// Shared definitions for the commit-side ADD+LOAD fusion split:
//   - core configuration record and its default
//   - committed scoreboard entry layout
//   - is_fusion encodings and the fusion_len() byte-advance decode
//   - retire FSM state encoding
package fusion_retire_split_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64, VLEN: 64};

    localparam int unsigned SB_PC_W = 64;

    typedef struct packed {
        logic valid;
    } sb_exception_t;

    typedef struct packed {
        logic [SB_PC_W-1:0] pc;
        logic               is_compressed;
        logic [1:0]         is_fusion;
        sb_exception_t      ex;
    } sb_entry_t;

    // is_fusion encodings: none, compressed+compressed, mixed, normal+normal
    localparam logic [1:0] FUS_NONE  = 2'b00;
    localparam logic [1:0] FUS_CC    = 2'b01;
    localparam logic [1:0] FUS_MIXED = 2'b10;
    localparam logic [1:0] FUS_NN    = 2'b11;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_SINGLE = 2'd1;
    localparam logic [1:0] ST_FIRST  = 2'd2;
    localparam logic [1:0] ST_SECOND = 2'd3;

    typedef enum logic [1:0] {
        RET_EMPTY  = ST_EMPTY,
        RET_SINGLE = ST_SINGLE,
        RET_FIRST  = ST_FIRST,
        RET_SECOND = ST_SECOND
    } fusion_ret_state_e;

    // Byte advance of a committed entry, fused or not.
    function automatic logic [3:0] fusion_len(input logic [1:0] is_fusion,
                                              input logic       is_compressed);
        logic [3:0] len;
        case (is_fusion)
            FUS_NONE:  len = is_compressed ? 4'd2 : 4'd4;
            FUS_CC:    len = 4'd4;
            FUS_MIXED: len = 4'd6;
            FUS_NN:    len = 4'd8;
            default:   len = 4'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fusion_retire_split.sv
// fusion_retire_split
// Re-expands committed fused ADD+LOAD entries into two architectural retire
// events (ADD half, then LOAD half), keeps instret correct and flags faulting
// fused entries so the frontend can refetch the pair unfused.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               drop any held / in-progress event
//   commit_valid_i/_ready_o, commit_entry_i   committed entry handshake
//   ret_valid_o/ret_ready_i                   retire event handshake
//   ret_pc_o, ret_npc_o, ret_npc_valid_o      event pc / next pc
//   ret_fused_add_o, ret_fused_load_o         which half of a fused pair
//   ret_ex_valid_o                            event carries an exception
//   instret_o                                 retired-instruction count
//   fusion_fault_o                            faulting fused entry pulse
//
// state  | meaning
// EMPTY  | no event held
// SINGLE | holding an unfused event or a faulting fused entry
// FIRST  | holding the ADD half of a fused pair; commit is stalled
// SECOND | holding the LOAD half of a fused pair
module fusion_retire_split
    import fusion_retire_split_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg            = cva6_cfg_empty,
    parameter type       scoreboard_entry_t = sb_entry_t
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      commit_valid_i,
    input  scoreboard_entry_t         commit_entry_i,
    output logic                      commit_ready_o,
    output logic                      ret_valid_o,
    input  logic                      ret_ready_i,
    output logic [CVA6Cfg.VLEN-1:0]   ret_pc_o,
    output logic [CVA6Cfg.VLEN-1:0]   ret_npc_o,
    output logic                      ret_npc_valid_o,
    output logic                      ret_fused_add_o,
    output logic                      ret_fused_load_o,
    output logic                      ret_ex_valid_o,
    output logic [63:0]               instret_o,
    output logic                      fusion_fault_o
);

    localparam int unsigned VLEN = CVA6Cfg.VLEN;

    logic [1:0]      state_q;
    logic [VLEN-1:0] pc_q;
    logic [VLEN-1:0] npc_q;
    logic            npc_valid_q;
    logic            add_q;
    logic            load_q;
    logic            ex_q;
    logic [63:0]     instret_q;
    logic            fault_q;

    logic            ret_hs;
    logic            commit_accept;
    logic            entry_fused;
    logic [3:0]      entry_len;
    logic [VLEN-1:0] entry_pc;

    assign ret_valid_o   = (state_q != ST_EMPTY);
    assign ret_hs        = ret_valid_o && ret_ready_i;

    assign commit_ready_o = !flush_i &&
                            ((state_q == ST_EMPTY) ||
                             (((state_q == ST_SINGLE) || (state_q == ST_SECOND)) && ret_ready_i));
    assign commit_accept  = commit_valid_i && commit_ready_o;

    always_comb begin
        entry_fused = (commit_entry_i.is_fusion != FUS_NONE);
        entry_len   = fusion_len(commit_entry_i.is_fusion, commit_entry_i.is_compressed);
        entry_pc    = VLEN'(commit_entry_i.pc);
    end

    // npc_q is always loaded with pc + full length; on the ADD half it is
    // simply not advertised, so the LOAD half needs no extra register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            pc_q        <= '0;
            npc_q       <= '0;
            npc_valid_q <= 1'b0;
            add_q       <= 1'b0;
            load_q      <= 1'b0;
            ex_q        <= 1'b0;
            instret_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            fault_q <= 1'b0;

            // A handshake in a flush cycle still retires its instruction.
            if (ret_hs && !ex_q) begin
                instret_q <= instret_q + 64'd1;
            end

            if (flush_i) begin
                state_q     <= ST_EMPTY;
                npc_valid_q <= 1'b0;
                add_q       <= 1'b0;
                load_q      <= 1'b0;
                ex_q        <= 1'b0;
            end else if (commit_accept) begin
                pc_q  <= entry_pc;
                npc_q <= entry_pc + VLEN'(entry_len);
                if (!entry_fused) begin
                    state_q     <= ST_SINGLE;
                    npc_valid_q <= 1'b1;
                    add_q       <= 1'b0;
                    load_q      <= 1'b0;
                    ex_q        <= commit_entry_i.ex.valid;
                end else if (commit_entry_i.ex.valid) begin
                    // Neither half retires; the pair is refetched unfused.
                    state_q     <= ST_SINGLE;
                    npc_valid_q <= 1'b0;
                    add_q       <= 1'b0;
                    load_q      <= 1'b0;
                    ex_q        <= 1'b1;
                    fault_q     <= 1'b1;
                end else begin
                    // The ADD's own length is unknown for mixed pairs, so
                    // its npc is never reported.
                    state_q     <= ST_FIRST;
                    npc_valid_q <= 1'b0;
                    add_q       <= 1'b1;
                    load_q      <= 1'b0;
                    ex_q        <= 1'b0;
                end
            end else if (ret_hs) begin
                if (state_q == ST_FIRST) begin
                    state_q     <= ST_SECOND;
                    npc_valid_q <= 1'b1;
                    add_q       <= 1'b0;
                    load_q      <= 1'b1;
                end else begin
                    state_q <= ST_EMPTY;
                end
            end
        end
    end

    assign ret_pc_o         = pc_q;
    assign ret_npc_o        = npc_q;
    assign ret_npc_valid_o  = npc_valid_q;
    assign ret_fused_add_o  = add_q;
    assign ret_fused_load_o = load_q;
    assign ret_ex_valid_o   = ex_q;
    assign instret_o        = instret_q;
    assign fusion_fault_o   = fault_q;

endmodule

// File: tb/tb_fusion_retire_split.sv
module tb_fusion_retire_split;
    import fusion_retire_split_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        commit_valid_i;
    sb_entry_t   commit_entry_i;
    logic        commit_ready_o;
    logic        ret_valid_o;
    logic        ret_ready_i;
    logic [63:0] ret_pc_o;
    logic [63:0] ret_npc_o;
    logic        ret_npc_valid_o;
    logic        ret_fused_add_o;
    logic        ret_fused_load_o;
    logic        ret_ex_valid_o;
    logic [63:0] instret_o;
    logic        fusion_fault_o;

    fusion_retire_split #(
        .CVA6Cfg           (cva6_cfg_empty),
        .scoreboard_entry_t(sb_entry_t)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .commit_valid_i  (commit_valid_i),
        .commit_entry_i  (commit_entry_i),
        .commit_ready_o  (commit_ready_o),
        .ret_valid_o     (ret_valid_o),
        .ret_ready_i     (ret_ready_i),
        .ret_pc_o        (ret_pc_o),
        .ret_npc_o       (ret_npc_o),
        .ret_npc_valid_o (ret_npc_valid_o),
        .ret_fused_add_o (ret_fused_add_o),
        .ret_fused_load_o(ret_fused_load_o),
        .ret_ex_valid_o  (ret_ex_valid_o),
        .instret_o       (instret_o),
        .fusion_fault_o  (fusion_fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] npc;
        logic        npc_valid;
        logic        add;
        logic        load;
        logic        ex;
    } exp_ev_t;

    exp_ev_t     exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          exp_faults = 0;
    int          fault_seen = 0;
    bit          stim_done = 0;
    bit          drv_timeout = 0;
    bit          rdy_rand = 0;
    bit          rdy_val = 1;

    // Reference: byte advance from the architectural encoding rules.
    function automatic logic [63:0] ref_len(input logic [1:0] fus, input logic c);
        if (fus == 2'b00) return c ? 64'd2 : 64'd4;
        return 64'd2 * 64'(fus) + 64'd2;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Ready driver
    initial begin
        ret_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            ret_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    end

    task automatic send(input logic [63:0] pc, input logic c, input logic [1:0] fus, input logic ex);
        exp_ev_t e;
        bit      done = 0;
        logic [63:0] len = ref_len(fus, c);
        commit_valid_i          = 1'b1;
        commit_entry_i.pc       = pc;
        commit_entry_i.is_compressed = c;
        commit_entry_i.is_fusion = fus;
        commit_entry_i.ex.valid = ex;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_i);
            if (commit_ready_o) begin
                done = 1;
                if (fus == 2'b00) begin
                    e = '{pc, pc + len, 1'b1, 1'b0, 1'b0, ex};
                    exp_q.push_back(e);
                end else if (ex) begin
                    e = '{pc, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1};
                    exp_q.push_back(e);
                    exp_faults++;
                end else begin
                    e = '{pc, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
                    exp_q.push_back(e);
                    e = '{pc, pc + len, 1'b1, 1'b0, 1'b1, 1'b0};
                    exp_q.push_back(e);
                end
                @(posedge clk_i);
                #1;
            end
        end
        if (!done) drv_timeout = 1;
        commit_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Stimulus
    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        commit_valid_i = 1'b0;
        commit_entry_i = '0;
        idle(3);
        rst_i = 1'b0;
        idle(2);

        send(64'h8000_0000, 1'b0, 2'b00, 1'b0);
        send(64'h8000_0004, 1'b1, 2'b00, 1'b0);
        idle(3);

        send(64'h1000, 1'b0, 2'b11, 1'b0);
        send(64'h2000, 1'b0, 2'b10, 1'b0);
        send(64'h3000, 1'b1, 2'b01, 1'b0);
        send(64'h1000, 1'b0, 2'b11, 1'b1);
        idle(3);

        rdy_val = 0;
        send(64'h4000, 1'b0, 2'b11, 1'b0);
        idle(3);
        rdy_val = 1;
        idle(4);

        send(64'h5000, 1'b0, 2'b11, 1'b0);
        idle(1);
        rdy_val = 0;
        flush_i = 1'b1;
        idle(1);
        flush_i = 1'b0;
        rdy_val = 1;
        idle(3);

        rdy_val = 0;
        send(64'h6000, 1'b0, 2'b11, 1'b0);
        idle(1);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        rdy_val = 1;
        idle(2);
        send(64'h7000, 1'b1, 2'b00, 1'b0);
        idle(2);

        rdy_rand = 1;
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                flush_i = 1'b1;
                idle(1);
                flush_i = 1'b0;
            end else begin
                send({32'h0, $urandom} & ~64'h1, 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
                if ($urandom_range(0, 5) == 0) idle(1);
            end
        end
        rdy_rand = 0;
        rdy_val = 1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || ret_valid_o); i++) idle(1);
        idle(2);
        stim_done = 1;
    end

    // Monitor / scoreboard
    initial begin
        exp_ev_t     e;
        int          cyc = 0;
        bit          prev_rst = 0;
        bit          prev_flush = 0;
        bit          prev_stall = 0;
        logic [63:0] model_instret = 0;
        logic [63:0] s_pc, s_npc;
        logic [4:0]  s_flags;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_i) begin
                exp_q.delete();
                model_instret = 0;
                prev_rst = 1;
                prev_stall = 0;
                prev_flush = 0;
                continue;
            end
            if (prev_rst) begin
                chk("reset_ret_valid", ret_valid_o, 0);
                chk("reset_commit_ready", commit_ready_o, 1);
                chk("reset_pc", ret_pc_o, 0);
                chk("reset_npc", ret_npc_o, 0);
                chk("reset_flags", {ret_npc_valid_o, ret_fused_add_o, ret_fused_load_o, ret_ex_valid_o}, 0);
                chk("reset_instret", instret_o, 0);
                chk("reset_fault", fusion_fault_o, 0);
                prev_rst = 0;
            end
            if (prev_flush) chk("flush_ret_valid", ret_valid_o, 0);
            chk("instret", instret_o, model_instret);
            chk("commit_ready", commit_ready_o,
                !flush_i && (!ret_valid_o || (!ret_fused_add_o && ret_ready_i)));
            if (prev_stall) begin
                chk("stall_valid", ret_valid_o, 1);
                chk("stall_pc", ret_pc_o, s_pc);
                chk("stall_npc", ret_npc_o, s_npc);
                chk("stall_flags", {ret_npc_valid_o, ret_fused_add_o, ret_fused_load_o, ret_ex_valid_o, 1'b0}, s_flags);
            end
            if (fusion_fault_o) begin
                fault_seen++;
                chk("fault_with_ex_event", ret_valid_o && ret_ex_valid_o, 1);
            end
            if (ret_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual pc=0x%0h required no event", ret_pc_o);
                end else begin
                    e = exp_q[0];
                    chk("ev_pc", ret_pc_o, e.pc);
                    chk("ev_npc_valid", ret_npc_valid_o, e.npc_valid);
                    chk("ev_fused_add", ret_fused_add_o, e.add);
                    chk("ev_fused_load", ret_fused_load_o, e.load);
                    chk("ev_ex_valid", ret_ex_valid_o, e.ex);
                    if (e.npc_valid) chk("ev_npc", ret_npc_o, e.npc);
                    if (ret_ready_i) begin
                        void'(exp_q.pop_front());
                        if (!e.ex) model_instret = model_instret + 1;
                    end
                end
            end
            prev_stall = ret_valid_o && !ret_ready_i && !flush_i;
            s_pc = ret_pc_o;
            s_npc = ret_npc_o;
            s_flags = {ret_npc_valid_o, ret_fused_add_o, ret_fused_load_o, ret_ex_valid_o, 1'b0};
            prev_flush = flush_i;
            if (flush_i) exp_q.delete();
            if (stim_done || cyc > 60000) begin
                if (!stim_done) begin
                    failures++;
                    $display("FAIL watchdog actual cycles=%0d required stimulus completion", cyc);
                end
                if (drv_timeout) begin
                    failures++;
                    $display("FAIL commit_accept_timeout actual=stuck required=accepted");
                end
                chk("fault_pulse_count", 64'(fault_seen), 64'(exp_faults));
                chk("queue_drained", 64'(exp_q.size()), 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

endmodule
